crot_stream: RTL and testbench

CROT_STREAM -- requirements
Module: crot_stream

---
 rtl/crot_stream_pkg.sv | 55 +++++
 rtl/crot_stream_twiddle_rom.sv | 53 +++++
 rtl/crot_stream.sv | 141 ++++++++++++++
 tb/tb_crot_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crot_stream_pkg.sv
// Shared fixed-point defaults and constant helpers for the crot_stream rotator.
// Everything here is evaluated at elaboration only.
package crot_stream_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 14;
  localparam int K_MAX_DEF = 8;
  localparam int TAG_W_DEF = 4;

  localparam real PI = 3.14159265358979323846;

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic longint rnd_half(input int frac);
    return longint'(1) <<< (frac - 1);
  endfunction

  function automatic int round_real(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  // Taylor series keeps the table generation free of tool math builtins.
  function automatic int twiddle(input int k, input int frac, input bit want_sin);
    real th, x2, term, acc, scale;
    th = 2.0 * PI;
    for (int n = 0; n < k; n++) th = th / 2.0;
    x2 = th * th;
    if (want_sin) begin
      term = th;
      acc  = th;
      for (int n = 1; n < 24; n++) begin
        term = -term * x2 / real'((2 * n) * (2 * n + 1));
        acc  = acc + term;
      end
    end else begin
      term = 1.0;
      acc  = 1.0;
      for (int n = 1; n < 24; n++) begin
        term = -term * x2 / real'((2 * n - 1) * (2 * n));
        acc  = acc + term;
      end
    end
    scale = 1.0;
    for (int n = 0; n < frac; n++) scale = scale * 2.0;
    return round_real(acc * scale);
  endfunction

endpackage

// File: rtl/crot_stream_twiddle_rom.sv
// Registered cos/sin lookup for theta = 2*pi/2^k; identity on ctrl=0, k=0 or k>K_MAX.
// Table contents are computed from K_MAX at elaboration.
module crot_twiddle_rom
  import crot_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int K_MAX = K_MAX_DEF,
  localparam int K_W  = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [K_W-1:0]          k,
  input  logic                    ctrl,
  input  logic                    inv,
  output logic signed [WIDTH-1:0] cos_q,
  output logic signed [WIDTH-1:0] sin_q
);

  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

  logic signed [WIDTH-1:0] cos_tbl [0:K_MAX];
  logic signed [WIDTH-1:0] sin_tbl [0:K_MAX];
  logic signed [WIDTH-1:0] cos_nxt, sin_nxt;
  logic                    ident;

  for (genvar g = 0; g <= K_MAX; g++) begin : gen_tbl
    assign cos_tbl[g] = WIDTH'(twiddle(g, FRAC, 1'b0));
    assign sin_tbl[g] = WIDTH'(twiddle(g, FRAC, 1'b1));
  end

  always_comb begin
    ident   = !ctrl || (k == '0) || (k > K_W'(K_MAX));
    cos_nxt = ONE;
    sin_nxt = '0;
    if (!ident) begin
      cos_nxt = cos_tbl[k];
      sin_nxt = inv ? -sin_tbl[k] : sin_tbl[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (en) begin
      cos_q <= cos_nxt;
      sin_q <= sin_nxt;
    end
  end

endmodule

// File: rtl/crot_stream.sv
// Streaming complex rotator: 4-stage pipeline (lookup, multiply, round, saturate)
// with a single global stall driven by output backpressure.
module crot_stream
  import crot_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int TAG_W = TAG_W_DEF,
  localparam int K_W  = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic signed [WIDTH-1:0] in_i,
  input  logic [K_W-1:0]          in_k,
  input  logic                    in_ctrl,
  input  logic                    in_inv,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_r,
  output logic signed [WIDTH-1:0] out_i,
  output logic [TAG_W-1:0]        out_tag,
  output logic [15:0]             sat_count
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic signed [SW-1:0]    RND    = SW'(rnd_half(FRAC));
  localparam logic signed [SW-1:0]    SAT_HI = SW'(sat_hi(WIDTH));
  localparam logic signed [SW-1:0]    SAT_LO = SW'(sat_lo(WIDTH));
  localparam logic signed [WIDTH-1:0] MAX_W  = WIDTH'(sat_hi(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_W  = WIDTH'(sat_lo(WIDTH));

  logic                    en;
  logic                    v1, v2, v3, sat4;
  logic [TAG_W-1:0]        tag1, tag2, tag3;
  logic signed [WIDTH-1:0] r1, i1, cos1, sin1;
  logic signed [PW-1:0]    p_rc, p_is, p_rs, p_ic;
  logic signed [SW-1:0]    re3, im3;
  logic signed [WIDTH-1:0] r_sat, i_sat;
  logic                    r_clip, i_clip;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  crot_twiddle_rom #(.WIDTH(WIDTH), .FRAC(FRAC), .K_MAX(K_MAX)) u_rom (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .k     (in_k),
    .ctrl  (in_ctrl),
    .inv   (in_inv),
    .cos_q (cos1),
    .sin_q (sin1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      r1   <= '0;
      i1   <= '0;
      tag1 <= '0;
      v2   <= 1'b0;
      p_rc <= '0;
      p_is <= '0;
      p_rs <= '0;
      p_ic <= '0;
      tag2 <= '0;
      v3   <= 1'b0;
      re3  <= '0;
      im3  <= '0;
      tag3 <= '0;
    end else if (en) begin
      v1   <= in_valid;
      r1   <= in_r;
      i1   <= in_i;
      tag1 <= in_tag;
      v2   <= v1;
      p_rc <= PW'(r1) * PW'(cos1);
      p_is <= PW'(i1) * PW'(sin1);
      p_rs <= PW'(r1) * PW'(sin1);
      p_ic <= PW'(i1) * PW'(cos1);
      tag2 <= tag1;
      v3   <= v2;
      // Round half up: add half an LSB, then floor via arithmetic shift.
      re3  <= ((SW'(p_rc) - SW'(p_is)) + RND) >>> FRAC;
      im3  <= ((SW'(p_rs) + SW'(p_ic)) + RND) >>> FRAC;
      tag3 <= tag2;
    end
  end

  always_comb begin
    r_sat  = WIDTH'(re3);
    r_clip = 1'b0;
    if (re3 > SAT_HI) begin
      r_sat  = MAX_W;
      r_clip = 1'b1;
    end else if (re3 < SAT_LO) begin
      r_sat  = MIN_W;
      r_clip = 1'b1;
    end
    i_sat  = WIDTH'(im3);
    i_clip = 1'b0;
    if (im3 > SAT_HI) begin
      i_sat  = MAX_W;
      i_clip = 1'b1;
    end else if (im3 < SAT_LO) begin
      i_sat  = MIN_W;
      i_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_tag   <= '0;
      sat4      <= 1'b0;
    end else if (en) begin
      out_valid <= v3;
      out_r     <= r_sat;
      out_i     <= i_sat;
      out_tag   <= tag3;
      sat4      <= r_clip | i_clip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && sat4 && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_crot_stream.sv
// Scoreboard bench for crot_stream: driver pushes model results, monitor pops on output handshakes.
module tb_crot_stream;

  localparam int WIDTH = 16;
  localparam int FRAC  = 14;
  localparam int K_MAX = 8;
  localparam int TAG_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_r = '0;
  logic signed [15:0] in_i = '0;
  logic [3:0]         in_k = '0;
  logic               in_ctrl = 1'b0;
  logic               in_inv = 1'b0;
  logic [3:0]         in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_r;
  logic signed [15:0] out_i;
  logic [3:0]         out_tag;
  logic [15:0]        sat_count;

  crot_stream #(.WIDTH(WIDTH), .FRAC(FRAC), .K_MAX(K_MAX), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .in_k      (in_k),
    .in_ctrl   (in_ctrl),
    .in_inv    (in_inv),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_tag   (out_tag),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int i;
    int tag;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_sat = 0;
  int   hold_low = 0;
  bit   rand_bp = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    else          return -longint'($rtoi(0.5 - x));
  endfunction

  // Reference: exact rotation with real-valued trig, rounded coefficients, round-half-up, clip.
  function automatic exp_t model(input int r, input int i, input int k,
                                 input bit ctrl, input bit inv, input int tag);
    exp_t   e;
    longint c, s, re, im, hi, lo;
    real    th;
    hi = 32767;
    lo = -32768;
    if (!ctrl || k == 0 || k > K_MAX) begin
      c = 16384;
      s = 0;
    end else begin
      th = 2.0 * 3.14159265358979323846 / (2.0 ** k);
      c  = rnd($cos(th) * 16384.0);
      s  = rnd($sin(th) * 16384.0);
      if (inv) s = -s;
    end
    re = (longint'(r) * c - longint'(i) * s + 8192) >>> 14;
    im = (longint'(r) * s + longint'(i) * c + 8192) >>> 14;
    e.sat = (re > hi) || (re < lo) || (im > hi) || (im < lo);
    e.r   = int'(re > hi ? hi : (re < lo ? lo : re));
    e.i   = int'(im > hi ? hi : (im < lo ? lo : im));
    e.tag = tag;
    return e;
  endfunction

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (hold_low > 0) begin
        out_ready = 1'b0;
        hold_low--;
      end else if (rand_bp) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  bit                 prev_stall = 1'b0;
  logic signed [15:0] prev_r, prev_i;
  logic [3:0]         prev_tag;
  logic               prev_v;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      exp_q.delete();
      exp_sat    = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("stall_hold_r", longint'(out_r), longint'(prev_r));
        check("stall_hold_i", longint'(out_i), longint'(prev_i));
        check("stall_hold_tag", longint'(out_tag), longint'(prev_tag));
        check("stall_hold_valid", longint'(out_valid), longint'(prev_v));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_r", longint'(out_r), longint'(e.r));
          check("out_i", longint'(out_i), longint'(e.i));
          check("out_tag", longint'(out_tag), longint'(e.tag));
          check("sat_count", longint'(sat_count), longint'(exp_sat));
          if (e.sat && exp_sat < 65535) exp_sat++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = out_r;
      prev_i     = out_i;
      prev_tag   = out_tag;
      prev_v     = out_valid;
    end
  end

  task automatic send(input int r, input int i, input int k,
                      input bit ctrl, input bit inv, input int tag);
    int n = 0;
    in_r     = 16'(r);
    in_i     = 16'(i);
    in_k     = 4'(k);
    in_ctrl  = ctrl;
    in_inv   = inv;
    in_tag   = 4'(tag);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else exp_q.push_back(model(r, i, k, ctrl, inv, tag));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", longint'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Called right after the acceptance edge with an empty pipeline and out_ready high.
  task automatic measure_latency(input string name);
    int lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, lat, 4);
  endtask

  initial begin : driver
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_r", longint'(out_r), 0);
    check("rst_out_i", longint'(out_i), 0);
    check("rst_out_tag", longint'(out_tag), 0);
    check("rst_sat_count", longint'(sat_count), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(16384, 0, 2, 1'b1, 1'b0, 1);
    measure_latency("latency");
    drain();
    check("sat_after_k2", longint'(sat_count), 0);
    send(16384, 0, 2, 1'b1, 1'b1, 2);
    send(16384, 0, 2, 1'b0, 1'b0, 3);
    send(1234, -567, 1, 1'b1, 1'b0, 4);
    send(1234, -567, 9, 1'b1, 1'b1, 5);
    send(-20000, 12345, 3, 1'b1, 1'b1, 6);
    drain();
    check("sat_before_clip", longint'(sat_count), 0);
    send(32767, 32767, 3, 1'b1, 1'b0, 7);
    drain();
    check("sat_after_clip", longint'(sat_count), 1);

    fork
      begin
        for (int t = 0; t < 6; t++)
          send($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
               $urandom_range(0, 9), 1'b1, 1'(t), t);
      end
      begin
        repeat (5) @(posedge clk);
        hold_low = 3;
      end
    join
    drain();

    send(-32768, -32768, 3, 1'b1, 1'b0, 8);
    send(100, 200, 4, 1'b1, 1'b0, 9);
    send(300, -400, 5, 1'b1, 1'b1, 10);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_sat_count", longint'(sat_count), 0);
    @(negedge clk);
    check("midrst_out_valid_next", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_beat", longint'(exp_q.size()), 0);
    send(-1000, 2000, 6, 1'b1, 1'b0, 11);
    measure_latency("latency_after_rst");
    drain();

    rand_bp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      send($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
           $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0), 1'($urandom),
           $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_bp = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
